// File: rtl/reg_readout.sv
// Snapshots {in4, in13} on start and shifts it out MSB-first over a
// valid/ready serial link, optionally followed by an even-parity bit.
module reg_readout #(
    parameter bit PARITY_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  in4,
    input  logic [12:0] in13,
    output logic        sout,
    output logic        sout_valid,
    input  logic        sout_ready,
    output logic        busy,
    output logic        done
);

    localparam int          NBITS    = 17;
    localparam logic [4:0]  LAST_BIT = 5'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [NBITS-1:0]  sreg;
    logic [4:0]        cnt;
    logic              par;

    // Outputs depend only on state and registered datapath, never on inputs.
    always_comb begin
        sout       = 1'b0;
        sout_valid = 1'b0;
        busy       = (state != IDLE);
        done       = (state == DONE);
        unique case (state)
            SHIFT: begin
                sout_valid = 1'b1;
                sout       = sreg[NBITS-1];
            end
            PARITY: begin
                sout_valid = 1'b1;
                sout       = par;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (start) state_nxt = SHIFT;
            SHIFT:  if (sout_ready && cnt == LAST_BIT)
                        state_nxt = PARITY_EN ? PARITY : DONE;
            PARITY: if (sout_ready) state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            par   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                sreg <= {in4, in13};
                cnt  <= '0;
                par  <= 1'b0;
            end else if (state == SHIFT && sout_ready) begin
                // Parity folds in the bit leaving on this transfer.
                sreg <= {sreg[NBITS-2:0], 1'b0};
                cnt  <= cnt + 5'd1;
                par  <= par ^ sreg[NBITS-1];
            end
        end
    end

endmodule

// File: tb/tb_reg_readout.sv
// Directed bench for reg_readout: parity and no-parity instances, stalls,
// held start, input churn after the snapshot, and mid-frame reset.
module tb_reg_readout;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        start0 = 1'b0;
    logic        sout_ready = 1'b1;
    logic [3:0]  in4 = '0;
    logic [12:0] in13 = '0;

    logic sout1, valid1, busy1, done1;
    logic sout0, valid0, busy0, done0;
    logic sel = 1'b0;
    logic o_sout, o_valid, o_busy, o_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_readout #(.PARITY_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .in4(in4), .in13(in13),
        .sout(sout1), .sout_valid(valid1), .sout_ready(sout_ready),
        .busy(busy1), .done(done1)
    );

    reg_readout #(.PARITY_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .in4(in4), .in13(in13),
        .sout(sout0), .sout_valid(valid0), .sout_ready(sout_ready),
        .busy(busy0), .done(done0)
    );

    assign o_sout  = sel ? sout0  : sout1;
    assign o_valid = sel ? valid0 : valid1;
    assign o_busy  = sel ? busy0  : busy1;
    assign o_done  = sel ? done0  : done1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in cycle 1 after the start edge; receives until done or timeout.
    task automatic collect(input bit tog, input bit scr, output logic [17:0] got,
                           output int nbits, output int stalls, output int dcyc);
        bit   pstall = 1'b0;
        logic psout  = 1'b0;
        got = '0; nbits = 0; stalls = 0; dcyc = -1;
        for (int cyc = 1; cyc < 200; cyc++) begin
            sout_ready = tog ? (cyc % 2 == 1) : 1'b1;
            if (pstall) begin
                chk("stall_valid", 32'(o_valid), 32'd1);
                chk("stall_sout", 32'(o_sout), 32'(psout));
            end
            if (!o_valid) chk("novalid_sout", 32'(o_sout), 32'd0);
            if (o_done) begin
                dcyc = cyc;
                break;
            end
            if (o_valid && sout_ready) begin
                got = {got[16:0], o_sout};
                nbits++;
            end
            if (o_valid && !sout_ready) stalls++;
            pstall = o_valid && !sout_ready;
            psout  = o_sout;
            if (scr) begin
                in4  = 4'($urandom);
                in13 = 13'($urandom);
            end
            tick();
        end
        sout_ready = 1'b1;
    endtask

    task automatic check_frame(input string tag, input logic [16:0] data, input bit par_en,
                               input logic [17:0] got, input int nbits, input int stalls,
                               input int dcyc);
        logic [17:0] exp;
        exp = par_en ? {data, ^data} : {1'b0, data};
        chk({tag, "_bits"}, 32'(got), 32'(exp));
        chk({tag, "_nbits"}, 32'(nbits), par_en ? 32'd18 : 32'd17);
        chk({tag, "_done_cyc"}, 32'(dcyc), 32'((par_en ? 19 : 18) + stalls));
    endtask

    task automatic do_frame(input string tag, input bit use0, input logic [3:0] a,
                            input logic [12:0] b, input bit tog, input bit scr);
        logic [17:0] got;
        int nb, st, dc;
        sel = use0;
        in4 = a; in13 = b;
        if (use0) start0 = 1'b1; else start = 1'b1;
        tick();
        start = 1'b0; start0 = 1'b0;
        chk({tag, "_busy"}, 32'(o_busy), 32'd1);
        collect(tog, scr, got, nb, st, dc);
        check_frame(tag, {a, b}, !use0, got, nb, st, dc);
        tick();
        chk({tag, "_done_pulse"}, 32'(o_done), 32'd0);
        chk({tag, "_idle"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        logic [17:0] got;
        int nb, st, dc;

        // Reset with start asserted: reset must win.
        start = 1'b1; start0 = 1'b1;
        tick(); tick();
        start = 1'b0; start0 = 1'b0;
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_valid", 32'(valid1), 32'd0);
        chk("rst_sout", 32'(sout1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);
        rst = 1'b1;
        tick();
        chk("post_rst_idle", 32'(busy1), 32'd0);

        // in4=A, in13=1555: nine ones, so even parity bit is 1.
        do_frame("basic", 1'b0, 4'hA, 13'h1555, 1'b0, 1'b0);
        do_frame("stall", 1'b0, 4'hA, 13'h1555, 1'b1, 1'b0);
        do_frame("churn", 1'b0, 4'h6, 13'h0B3C, 1'b0, 1'b1);
        do_frame("churn_stall", 1'b0, 4'h9, 13'h1E01, 1'b1, 1'b1);

        // start held high: second frame begins right after one IDLE cycle.
        sel = 1'b0;
        in4 = 4'h3; in13 = 13'h0F0F;
        start = 1'b1;
        tick();
        collect(1'b0, 1'b0, got, nb, st, dc);
        check_frame("hold1", 17'h07F0F & {4'h3, 13'h0F0F}, 1'b1, got, nb, st, dc);
        tick();
        chk("hold_gap_busy", 32'(o_busy), 32'd0);
        chk("hold_gap_done", 32'(o_done), 32'd0);
        tick();
        chk("hold_restart_busy", 32'(o_busy), 32'd1);
        chk("hold_restart_valid", 32'(o_valid), 32'd1);
        start = 1'b0;
        collect(1'b0, 1'b0, got, nb, st, dc);
        check_frame("hold2", {4'h3, 13'h0F0F}, 1'b1, got, nb, st, dc);
        tick();
        chk("hold_end_idle", 32'(o_busy), 32'd0);

        // Reset while bit 8 is on the line aborts the frame without done.
        in4 = 4'hF; in13 = 13'h1ABC;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("mid_valid_before", 32'(o_valid), 32'd1);
        rst = 1'b0;
        tick();
        chk("abort_sout", 32'(o_sout), 32'd0);
        chk("abort_valid", 32'(o_valid), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_done || o_busy) chk("abort_quiet", 32'({o_busy, o_done}), 32'd0);
        end
        do_frame("zeros", 1'b0, 4'h0, 13'h0000, 1'b0, 1'b0);

        // No-parity instance: 17 ones, done 18 cycles after start.
        do_frame("nopar_ones", 1'b1, 4'hF, 13'h1FFF, 1'b0, 1'b0);
        do_frame("nopar_stall", 1'b1, 4'h5, 13'h0A5A, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
